// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor.
// Each BLOCK-bit group gets its own register stage. The group carry ripples
// from one stage to the next through registers. The unconsumed upper operand
// bits and the finished lower sum bits travel forward with the beat.
// A global stall, taken from the output handshake, freezes every stage, so
// bubbles are never squeezed out of the pipeline.
module pipelined_cla_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int N = WIDTH / BLOCK;

    generate
        if (WIDTH <= 0 || BLOCK <= 0 || (WIDTH % BLOCK) != 0) begin : g_bad_width
            $error("pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK");
        end
    endgenerate

    // Returns the carry into every bit of the group plus the group carry-out.
    // Each carry is written as a flat sum of products, with no ripple between bits.
    function automatic logic [BLOCK:0] group_carries(input logic [BLOCK-1:0] g,
                                                     input logic [BLOCK-1:0] p,
                                                     input logic             cin);
        logic [BLOCK:0] c;
        logic           term;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            term = cin;
            for (int j = 0; j <= i; j++) term = term & p[j];
            c[i+1] = term;
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int m = j + 1; m <= i; m++) term = term & p[m];
                c[i+1] = c[i+1] | term;
            end
        end
        return c;
    endfunction

    logic             stall;
    logic             ch_valid [N];
    logic [WIDTH-1:0] ch_a     [N];
    logic [WIDTH-1:0] ch_b     [N];
    logic [WIDTH-1:0] ch_sum   [N];
    logic             ch_carry [N];

    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;

    // Subtraction is handled as a + ~b + ~c_in. It is folded in at the input,
    // so every stage sees a plain add.
    assign ch_valid[0] = in_valid;
    assign ch_a[0]     = a;
    assign ch_b[0]     = sub ? ~b : b;
    assign ch_carry[0] = sub ? ~c_in : c_in;
    assign ch_sum[0]   = '0;

    generate
        for (genvar k = 0; k < N; k++) begin : g_stage
            logic [BLOCK-1:0] ga, gb, gg, gp;
            logic [BLOCK:0]   gc;
            logic [WIDTH-1:0] next_sum;

            assign ga = ch_a[k][k*BLOCK +: BLOCK];
            assign gb = ch_b[k][k*BLOCK +: BLOCK];
            assign gg = ga & gb;
            assign gp = ga ^ gb;
            assign gc = group_carries(gg, gp, ch_carry[k]);

            // Merge this group's sum bits into the partial result carried by the beat
            always_comb begin
                next_sum                    = ch_sum[k];
                next_sum[k*BLOCK +: BLOCK]  = gp ^ gc[BLOCK-1:0];
            end

            if (k < N - 1) begin : g_mid
                logic             v_q;
                logic [WIDTH-1:0] a_q, b_q, sum_q;
                logic             c_q;

                // Intermediate stage register; data only loads with a valid beat
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        v_q   <= 1'b0;
                        a_q   <= '0;
                        b_q   <= '0;
                        sum_q <= '0;
                        c_q   <= 1'b0;
                    end else if (!stall) begin
                        v_q <= ch_valid[k];
                        if (ch_valid[k]) begin
                            a_q   <= ch_a[k];
                            b_q   <= ch_b[k];
                            sum_q <= next_sum;
                            c_q   <= gc[BLOCK];
                        end
                    end
                end

                assign ch_valid[k+1] = v_q;
                assign ch_a[k+1]     = a_q;
                assign ch_b[k+1]     = b_q;
                assign ch_sum[k+1]   = sum_q;
                assign ch_carry[k+1] = c_q;
            end else begin : g_last
                // Final stage drives the registered outputs; they hold through stalls and bubbles
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        out_valid <= 1'b0;
                        sum       <= '0;
                        c_out     <= 1'b0;
                        overflow  <= 1'b0;
                    end else if (!stall) begin
                        out_valid <= ch_valid[k];
                        if (ch_valid[k]) begin
                            sum      <= next_sum;
                            c_out    <= gc[BLOCK];
                            overflow <= gc[BLOCK] ^ gc[BLOCK-1];
                        end
                    end
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Self-checking bench for pipelined_cla_adder (WIDTH=16, BLOCK=4).
module tb_pipelined_cla_adder;

    localparam int NRAND = 10000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic        c_in, sub;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        c_out;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs [9];

    pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .sub      (sub),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .c_out    (c_out),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Arithmetic reference: returns {overflow, c_out, sum}
    function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                          input logic mc, input logic ms);
        int          ua, ub, sa, sb, ru, rs;
        logic        co, ov;
        logic [15:0] s;
        ua = int'(ma);
        ub = int'(mb);
        sa = int'($signed(ma));
        sb = int'($signed(mb));
        if (!ms) begin
            ru = ua + ub + int'(mc);
            rs = sa + sb + int'(mc);
            co = (ru > 65535);
        end else begin
            ru = ua - ub - int'(mc);
            rs = sa - sb - int'(mc);
            co = (ru >= 0);
        end
        s  = ru[15:0];
        ov = (rs > 32767) || (rs < -32768);
        return {ov, co, s};
    endfunction

    // One isolated beat: checks latency and result
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        bit got;
        @(negedge clk);
        a = v.a; b = v.b; c_in = v.cin; sub = v.sub; in_valid = 1'b1;
        #1 check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(negedge clk);
            in_valid = 1'b0;
            lat++;
            if (out_valid) got = 1;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_sum"},     32'(sum), 32'(v.s));
        check({tag, "_c_out"},   32'(c_out), 32'(v.co));
        check({tag, "_ovf"},     32'(overflow), 32'(v.ov));
    endtask

    initial begin
        logic [15:0] exp_s [8];
        logic [17:0] exp_q [$];
        logic [17:0] e;
        int tx, rx, stall_left, low_cnt, seen, spurious, cyc;

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h1234, 16'h0FED, 1'b1, 1'b0, 16'h2222, 1'b0, 1'b0};
        vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0};
        vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[7] = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[8] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum",       32'(sum),       32'd0);
        check("rst_c_out",     32'(c_out),     32'd0);
        check("rst_ovf",       32'(overflow),  32'd0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors
        for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Streaming with a 3-cycle stall at first result
        for (int i = 0; i < 8; i++) exp_s[i] = 16'((i + 1) + 'h1000 * (i + 1));
        tx = 0; rx = 0; seen = 0; stall_left = 0; low_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (seen == 0 && out_valid) begin seen = 1; stall_left = 3; end
            out_ready = (stall_left == 0);
            if (stall_left > 0) stall_left--;
            #1;
            if (!in_ready) begin
                low_cnt++;
                check("stream_stall_valid", 32'(out_valid), 32'd1);
                check("stream_hold_sum", 32'(sum), 32'(exp_s[0]));
            end
            if (out_valid && out_ready) begin
                if (rx < 8) begin
                    check("stream_sum",   32'(sum),      32'(exp_s[rx]));
                    check("stream_c_out", 32'(c_out),    32'd0);
                    check("stream_ovf",   32'(overflow), 32'd0);
                end
                rx++;
            end
            if (tx < 8) begin
                in_valid = 1'b1; a = 16'(tx + 1); b = 16'('h1000 * (tx + 1)); c_in = 1'b0; sub = 1'b0;
            end else begin
                in_valid = 1'b0;
            end
            #1 if (in_valid && in_ready) tx++;
        end
        in_valid = 1'b0;
        check("stream_first_seen", 32'(seen), 32'd1);
        check("stream_count", 32'(rx), 32'd8);
        check("stream_in_ready_low_cycles", 32'(low_cnt), 32'd3);

        // Reset mid-flight
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; a = 16'(16'h0100 + i); b = 16'h0011; c_in = 1'b0; sub = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 10) begin @(negedge clk); cyc++; end
        check("midrst_out_valid_before", 32'(out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid_async", 32'(out_valid), 32'd0);
        check("midrst_sum_async",       32'(sum),       32'd0);
        check("midrst_in_ready",        32'(in_ready),  32'd1);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        spurious = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        check("midrst_no_stale", 32'(spurious), 32'd0);
        run_vec(vecs[2], "midrst_next");

        // Random traffic with random backpressure
        tx = 0; rx = 0; cyc = 0;
        while (rx < NRAND && cyc < 80000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rand_result", 32'({overflow, c_out, sum}), 32'(e));
                end else begin
                    check("rand_unexpected_result", 32'(out_valid), 32'd0);
                end
                rx++;
            end
            if (tx < NRAND && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                a    = 16'($urandom_range(0, 65535));
                b    = 16'($urandom_range(0, 65535));
                c_in = 1'($urandom_range(0, 1));
                sub  = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            #1 if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, c_in, sub));
                tx++;
            end
        end
        in_valid = 1'b0;
        check("rand_count", 32'(rx), 32'(NRAND));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
